// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU op-code constants and default occupancy latencies, used by the
// issue controller, the MDU itself and the hazard unit.
package mdu_issue_ctrl_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFLO  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_IDLE  = 4'd15;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_MTHI;
    endfunction

    function automatic logic is_mult(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mf(input logic [3:0] op);
        return (op == OP_MFLO) || (op == OP_MFHI);
    endfunction

endpackage

// File: rtl/mdu_req_fifo.sv
// Synchronous request FIFO with flush; occupancy is tracked by a count
// register so full/empty never need pointer comparison.
module mdu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 73
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Pipeline-side MDU controller: queues E-stage ops, issues them under a shadow
// occupancy countdown, returns MF results and cross-checks the MDU busy flag.
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 5,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [3:0]       mdu_op,
    output logic [31:0]      mdu_num_a,
    output logic [31:0]      mdu_num_b,
    input  logic             mdu_busy,
    input  logic [31:0]      mdu_out,
    output logic             resp_valid,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_data,
    output logic             pending,
    output logic             err
);
    localparam int PW      = 4 + 32 + 32 + TAG_W;
    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [PW-1:0]          wdata;
    logic [PW-1:0]          head;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;

    logic [3:0]             head_op;
    logic [31:0]            head_a;
    logic [31:0]            head_b;
    logic [TAG_W-1:0]       head_tag;

    logic                   enq;
    logic                   push;
    logic                   issue;
    logic                   busy_err;
    logic [CNT_W-1:0]       shadow_cnt;

    assign wdata    = {req_op, req_a, req_b, req_tag};
    assign head_op  = head[PW-1 -: 4];
    assign head_a   = head[TAG_W+63 -: 32];
    assign head_b   = head[TAG_W+31 -: 32];
    assign head_tag = head[TAG_W-1:0];

    // Illegal op codes are swallowed (ready stays high) but never stored.
    assign enq       = req_valid && req_ready;
    assign push      = enq && is_legal(req_op);
    assign req_ready = !full;

    mdu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (issue),
        .wdata (wdata),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Issue depends only on registered state, never on mdu_busy.
    assign issue     = !empty && (shadow_cnt == '0) && !flush;
    assign mdu_op    = issue ? head_op : OP_IDLE;
    assign mdu_num_a = issue ? head_a  : 32'd0;
    assign mdu_num_b = issue ? head_b  : 32'd0;
    assign pending   = (count != '0) || (shadow_cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_cnt <= '0;
        end else if (issue && is_mult(head_op)) begin
            shadow_cnt <= CNT_W'(MULT_LAT);
        end else if (issue && is_div(head_op)) begin
            shadow_cnt <= CNT_W'(DIV_LAT);
        end else if (shadow_cnt != '0) begin
            shadow_cnt <= shadow_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_tag   <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= issue && is_mf(head_op);
            if (issue && is_mf(head_op)) begin
                resp_tag  <= head_tag;
                resp_data <= mdu_out;
            end
        end
    end

    // The shadow count must mirror MDU busy exactly; the issue cycle itself is exempt.
    assign busy_err = ((shadow_cnt != '0) && !mdu_busy) ||
                      ((shadow_cnt == '0) && !issue && mdu_busy);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (busy_err || (enq && !is_legal(req_op))) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with a small behavioural MDU providing
// busy and HI/LO read data.
module tb_mdu_issue_ctrl;

    localparam logic [3:0] MULT = 4'd0, MULTU = 4'd1, DIV = 4'd2, DIVU = 4'd3;
    localparam logic [3:0] MFLO = 4'd4, MFHI = 4'd5, MTLO = 4'd6, MTHI = 4'd7;
    localparam logic [3:0] IDLE = 4'd15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [4:0]  req_tag = 5'd0;
    logic [3:0]  mdu_op;
    logic [31:0] mdu_num_a;
    logic [31:0] mdu_num_b;
    logic        mdu_busy;
    logic [31:0] mdu_out;
    logic        resp_valid;
    logic [4:0]  resp_tag;
    logic [31:0] resp_data;
    logic        pending;
    logic        err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .mdu_op     (mdu_op),
        .mdu_num_a  (mdu_num_a),
        .mdu_num_b  (mdu_num_b),
        .mdu_busy   (mdu_busy),
        .mdu_out    (mdu_out),
        .resp_valid (resp_valid),
        .resp_tag   (resp_tag),
        .resp_data  (resp_data),
        .pending    (pending),
        .err        (err)
    );

    // Behavioural MDU: busy for 5/10 cycles after a MULT/DIV is presented.
    logic [31:0] hi, lo;
    int          busy_cnt;
    logic        inject_idle = 1'b0;
    logic [63:0] sprod, uprod;

    assign sprod    = $signed({{32{mdu_num_a[31]}}, mdu_num_a}) * $signed({{32{mdu_num_b[31]}}, mdu_num_b});
    assign uprod    = {32'd0, mdu_num_a} * {32'd0, mdu_num_b};
    assign mdu_busy = (busy_cnt != 0) && !inject_idle;
    assign mdu_out  = (mdu_op == MFHI) ? hi : lo;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= 0;
        end else begin
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            case (mdu_op)
                MULT:  begin {hi, lo} <= sprod; busy_cnt <= 5; end
                MULTU: begin {hi, lo} <= uprod; busy_cnt <= 5; end
                DIV: begin
                    if (mdu_num_b != 0) begin
                        lo <= $signed(mdu_num_a) / $signed(mdu_num_b);
                        hi <= $signed(mdu_num_a) % $signed(mdu_num_b);
                    end
                    busy_cnt <= 10;
                end
                DIVU: begin
                    if (mdu_num_b != 0) begin
                        lo <= mdu_num_a / mdu_num_b;
                        hi <= mdu_num_a % mdu_num_b;
                    end
                    busy_cnt <= 10;
                end
                MTLO:    lo <= mdu_num_a;
                MTHI:    hi <= mdu_num_a;
                default: ;
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
    endtask

    task automatic do_reset;
        req_valid = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++; if (mdu_op !== IDLE) begin errors++; $display("FAIL reset_mdu_op got=%0d want=15", mdu_op); end
        checks++; if (mdu_num_a !== 32'd0 || mdu_num_b !== 32'd0) begin errors++; $display("FAIL reset_operands got=%h/%h want=0/0", mdu_num_a, mdu_num_b); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        checks++; if (pending !== 1'b0 || err !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL reset_status got pend=%b err=%b rv=%b want 0/0/0", pending, err, resp_valid); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mult_mflo;
        drive(MULT, 32'hFFFF_FFFE, 32'd3, 5'd0);
        tick();
        checks++; if (mdu_op !== MULT || mdu_num_a !== 32'hFFFF_FFFE || mdu_num_b !== 32'd3) begin errors++; $display("FAIL mult_issue got op=%0d a=%h b=%h want 0/fffffffe/3", mdu_op, mdu_num_a, mdu_num_b); end
        drive(MFLO, 32'd0, 32'd0, 5'd8);
        tick();
        req_valid = 1'b0;
        for (int i = 2; i <= 6; i++) begin
            checks++; if (mdu_op !== IDLE) begin errors++; $display("FAIL mult_stall cycle t+%0d got=%0d want=15", i, mdu_op); end
            tick();
        end
        checks++; if (mdu_op !== MFLO) begin errors++; $display("FAIL mflo_issue_t7 got=%0d want=4", mdu_op); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FFFA || resp_tag !== 5'd8) begin errors++; $display("FAIL mflo_resp got v=%b d=%h t=%0d want 1/fffffffa/8", resp_valid, resp_data, resp_tag); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_pulse got=%b want=0", resp_valid); end
        drive(MFHI, 32'd0, 32'd0, 5'd9);
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FFFF || resp_tag !== 5'd9) begin errors++; $display("FAIL mfhi_resp got v=%b d=%h t=%0d want 1/ffffffff/9", resp_valid, resp_data, resp_tag); end
        tick();
    endtask

    task automatic test_div;
        drive(DIV, 32'd7, 32'd2, 5'd0);
        tick();
        checks++; if (mdu_op !== DIV) begin errors++; $display("FAIL div_issue got=%0d want=2", mdu_op); end
        drive(MFHI, 32'd0, 32'd0, 5'd2);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++; if (mdu_op !== IDLE || pending !== 1'b1) begin errors++; $display("FAIL div_stall %0d got op=%0d pend=%b want 15/1", i, mdu_op, pending); end
            tick();
        end
        checks++; if (mdu_op !== MFHI) begin errors++; $display("FAIL mfhi_after_div got=%0d want=5", mdu_op); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd1 || resp_tag !== 5'd2) begin errors++; $display("FAIL div_rem got v=%b d=%h t=%0d want 1/1/2", resp_valid, resp_data, resp_tag); end
        drive(MFLO, 32'd0, 32'd0, 5'd3);
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd3 || resp_tag !== 5'd3) begin errors++; $display("FAIL div_quot got v=%b d=%h t=%0d want 1/3/3", resp_valid, resp_data, resp_tag); end
        tick();
    endtask

    task automatic test_full;
        int waited;
        drive(DIV, 32'd100, 32'd7, 5'd0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(MTLO, k, 32'd0, 5'd0);
            tick();
            checks++; if (req_ready !== (k < 4)) begin errors++; $display("FAIL full_ready after push %0d got=%b want=%b", k, req_ready, (k < 4)); end
        end
        drive(MTLO, 32'd5, 32'd0, 5'd0);
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            waited++;
            if (mdu_op !== IDLE) break;
        end
        checks++; if (waited != 7) begin errors++; $display("FAIL full_first_pop cycles got=%0d want=7", waited); end
        checks++; if (mdu_op !== MTLO || mdu_num_a !== 32'd1 || req_ready !== 1'b0) begin errors++; $display("FAIL full_pop1 got op=%0d a=%0d rdy=%b want 6/1/0", mdu_op, mdu_num_a, req_ready); end
        tick();
        checks++; if (req_ready !== 1'b1 || mdu_op !== MTLO || mdu_num_a !== 32'd2) begin errors++; $display("FAIL full_pop2 got rdy=%b op=%0d a=%0d want 1/6/2", req_ready, mdu_op, mdu_num_a); end
        tick();
        req_valid = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            checks++; if (mdu_op !== MTLO || mdu_num_a !== k) begin errors++; $display("FAIL full_drain %0d got op=%0d a=%0d want 6/%0d", k, mdu_op, mdu_num_a, k); end
            tick();
        end
        checks++; if (mdu_op !== IDLE || pending !== 1'b0) begin errors++; $display("FAIL full_empty got op=%0d pend=%b want 15/0", mdu_op, pending); end
        drive(MFLO, 32'd0, 32'd0, 5'd7);
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd5) begin errors++; $display("FAIL full_last_lo got v=%b d=%0d want 1/5", resp_valid, resp_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL no_err_so_far got=%b want=0", err); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ops [4];
        logic [31:0] av  [4];
        logic [4:0]  tg  [4];
        ops = '{MTHI, MTLO, MFHI, MFLO};
        av  = '{32'h1234, 32'h55, 32'd0, 32'd0};
        tg  = '{5'd0, 5'd0, 5'd3, 5'd4};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], av[i], 32'd0, tg[i]);
            tick();
            checks++; if (mdu_op !== ops[i] || mdu_num_a !== av[i]) begin errors++; $display("FAIL stream_issue %0d got op=%0d a=%h want %0d/%h", i, mdu_op, mdu_num_a, ops[i], av[i]); end
        end
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h1234 || resp_tag !== 5'd3) begin errors++; $display("FAIL stream_resp0 got v=%b d=%h t=%0d want 1/1234/3", resp_valid, resp_data, resp_tag); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h55 || resp_tag !== 5'd4) begin errors++; $display("FAIL stream_resp1 got v=%b d=%h t=%0d want 1/55/4", resp_valid, resp_data, resp_tag); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stream_end got=%b want=0", resp_valid); end
    endtask

    task automatic test_flush;
        drive(MULT, 32'd6, 32'd7, 5'd0);
        tick();
        drive(MTLO, 32'hDEAD, 32'd0, 5'd0);
        tick();
        drive(MTHI, 32'hBEEF, 32'd0, 5'd0);
        tick();
        drive(MFLO, 32'd0, 32'd0, 5'd9);
        tick();
        drive(MTLO, 32'h1111, 32'd0, 5'd0);
        flush = 1'b1;
        #1;
        checks++; if (mdu_op !== IDLE || pending !== 1'b1) begin errors++; $display("FAIL flush_cycle got op=%0d pend=%b want 15/1", mdu_op, pending); end
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (mdu_op !== IDLE || resp_valid !== 1'b0) begin errors++; $display("FAIL flush_no_issue %0d got op=%0d rv=%b want 15/0", i, mdu_op, resp_valid); end
            tick();
        end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL flush_pending got=%b want=0", pending); end
        drive(MFLO, 32'd0, 32'd0, 5'd1);
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd42 || resp_tag !== 5'd1) begin errors++; $display("FAIL flush_lo_kept got v=%b d=%h t=%0d want 1/2a/1", resp_valid, resp_data, resp_tag); end
        tick();
    endtask

    task automatic test_reset_mid_div;
        drive(DIV, 32'd9, 32'd4, 5'd0);
        tick();
        drive(MFLO, 32'd0, 32'd0, 5'd6);
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (pending !== 1'b0 || mdu_op !== IDLE || err !== 1'b0) begin errors++; $display("FAIL midreset got pend=%b op=%0d err=%b want 0/15/0", pending, mdu_op, err); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++; if (resp_valid !== 1'b0 || err !== 1'b0 || mdu_op !== IDLE) begin errors++; $display("FAIL postreset %0d got rv=%b err=%b op=%0d want 0/0/15", i, resp_valid, err, mdu_op); end
            tick();
        end
    endtask

    task automatic test_err;
        drive(MULT, 32'd2, 32'd3, 5'd0);
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pre got=%b want=0", err); end
        inject_idle = 1'b1;
        tick();
        inject_idle = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_busy_rise got=%b want=1", err); end
        repeat (8) tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_busy_sticky got=%b want=1", err); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b want=0", err); end
        drive(4'd9, 32'd1, 32'd1, 5'd1);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready got=%b want=1", req_ready); end
        tick();
        req_valid = 1'b0;
        checks++; if (err !== 1'b1 || pending !== 1'b0) begin errors++; $display("FAIL illegal_op got err=%b pend=%b want 1/0", err, pending); end
        repeat (4) tick();
        checks++; if (err !== 1'b1 || mdu_op !== IDLE) begin errors++; $display("FAIL illegal_sticky got err=%b op=%0d want 1/15", err, mdu_op); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_mult_mflo();
        test_div();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_mid_div();
        test_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
